// File: rtl/uart_arb_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding and default channel count.
// Optional requester lock is enabled with the UART_ARB_LOCK_EN macro.
package uart_arb_pkg;

  localparam int NUM_REQ_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the UART transmit arbiter.
// req_lock only exists when UART_ARB_LOCK_EN is defined.
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT
) ();

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
`ifdef UART_ARB_LOCK_EN
  logic [NUM_REQ-1:0]   req_lock;
`endif
  logic [7:0]           tx_din;
  logic                 tx_wr_en;
  logic                 tx_busy;

`ifdef UART_ARB_LOCK_EN
  modport master (
    output req_valid, req_data, req_lock, tx_busy,
    input  req_ready, tx_din, tx_wr_en
  );

  modport slave (
    input  req_valid, req_data, req_lock, tx_busy,
    output req_ready, tx_din, tx_wr_en
  );
`else
  modport master (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_din, tx_wr_en
  );

  modport slave (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_din, tx_wr_en
  );
`endif

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin search: first set bit of req after last_grant, wrapping around.
// Kept standalone so the receive-side dispatcher can reuse it.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEFAULT,
  localparam int GRANT_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] last_grant,
  output logic [GRANT_W-1:0] winner,
  output logic               any_valid
);

  logic [GRANT_W-1:0] idx;

  // Walk from the farthest candidate toward the nearest so the nearest valid one wins.
  always_comb begin
    winner = last_grant;
    idx    = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = GRANT_W'((int'(last_grant) + off) % NUM_REQ);
      if (req[idx]) begin
        winner = idx;
      end
    end
  end

  assign any_valid = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers, one byte per frame.
// Define UART_ARB_LOCK_EN to let a requester hold the grant across a multi-byte message.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEFAULT,
  localparam int GRANT_W = $clog2(NUM_REQ)
) (
  input  logic               clk_50m,
  input  logic               rst,
  uart_tx_arbiter_if.slave   bus,
  output logic [GRANT_W-1:0] grant_id,
  output logic               active
);

  arb_state_t         state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [7:0]         din_q, din_d;
  logic [NUM_REQ-1:0] ready_c;
  logic [GRANT_W-1:0] rr_winner;
  logic               rr_any;
  logic [GRANT_W-1:0] pick;
  logic [7:0]         data_arr [NUM_REQ];
`ifdef UART_ARB_LOCK_EN
  logic               lock_q, lock_d;
`endif

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = bus.req_data[8*i +: 8];
    end
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req        (bus.req_valid),
    .last_grant (grant_q),
    .winner     (rr_winner),
    .any_valid  (rr_any)
  );

  // Acceptance is suppressed during reset so no byte is handshaken and then discarded.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    din_d   = din_q;
    ready_c = '0;
    pick    = rr_winner;
`ifdef UART_ARB_LOCK_EN
    lock_d  = lock_q;
    if (lock_q && bus.req_valid[grant_q]) begin
      pick = grant_q;
    end
`endif
    case (state_q)
      ST_IDLE: begin
        if (!bus.tx_busy && rr_any && !rst) begin
          ready_c[pick] = 1'b1;
          grant_d       = pick;
          din_d         = data_arr[pick];
          state_d       = ST_ISSUE;
`ifdef UART_ARB_LOCK_EN
          lock_d        = 1'b0;
`endif
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          state_d = ST_IDLE;
`ifdef UART_ARB_LOCK_EN
          lock_d  = bus.req_lock[grant_q];
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // grant_id resets to the last index so requester 0 is first in line.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= GRANT_W'(NUM_REQ - 1);
      din_q   <= 8'h00;
`ifdef UART_ARB_LOCK_EN
      lock_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      din_q   <= din_d;
`ifdef UART_ARB_LOCK_EN
      lock_q  <= lock_d;
`endif
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.tx_din    = din_q;
  assign bus.tx_wr_en  = (state_q == ST_ISSUE);
  assign grant_id      = grant_q;
  assign active        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a 20-cycle transmitter model.
// Lock scenario is compiled only when UART_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int N        = 4;
  localparam int GW       = 2;
  localparam int BUSY_LEN = 20;
  localparam int MAX_LIT  = 32;

  logic          clk_50m = 1'b0;
  logic          rst     = 1'b1;
  logic [GW-1:0] grant_id;
  logic          active;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N)) dut (
    .clk_50m  (clk_50m),
    .rst      (rst),
    .bus      (bus),
    .grant_id (grant_id),
    .active   (active)
  );

  always #10 clk_50m = ~clk_50m;

  // Transmitter: busy rises the cycle after wr_en and stays up BUSY_LEN cycles; not reset by rst.
  int   tx_cnt   = 0;
  logic ext_busy = 1'b0;
  always @(posedge clk_50m) begin
    if (bus.tx_wr_en) tx_cnt <= BUSY_LEN;
    else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
  end
  assign bus.tx_busy = (tx_cnt != 0) || ext_busy;

  logic [7:0] src_q [N][$];
  logic [7:0] lit_din [MAX_LIT];
  int         lit_gid [MAX_LIT];
  int         lit_cnt = 0;
  int         lit_rd  = 0;

  int n_vec  = 0;
  int n_fail = 0;
  bit final_req  = 1'b0;
  bit final_done = 1'b0;

  bit         m_pending = 1'b0;
  bit         m_inflight = 1'b0;
  bit         m_seen = 1'b0;
  bit         m_lock = 1'b0;
  int         m_last = N - 1;
  logic [7:0] m_din = 8'h00;
  logic [N-1:0] exp_ready;
  int         win;
  bit         free_now;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_vec++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  function automatic int rrWinner(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[GW'((last + k) % N)]) return (last + k) % N;
    end
    return last;
  endfunction

  // Compare process: transaction-level model of who may be granted and when.
  initial begin
    forever begin
      @(negedge clk_50m);
      if (rst) begin
        m_pending  = 1'b0;
        m_inflight = 1'b0;
        m_seen     = 1'b0;
        m_lock     = 1'b0;
        m_last     = N - 1;
        m_din      = 8'h00;
      end else begin
        free_now = !m_pending && !m_inflight;
        win = rrWinner(bus.req_valid, m_last);
`ifdef UART_ARB_LOCK_EN
        if (m_lock && bus.req_valid[m_last[GW-1:0]]) win = m_last;
`endif
        exp_ready = (free_now && !bus.tx_busy && (|bus.req_valid)) ? (N'(1) << win) : '0;
        checkOutput("req_ready", int'(bus.req_ready), int'(exp_ready));
        checkOutput("tx_wr_en", int'(bus.tx_wr_en), int'(m_pending));
        checkOutput("tx_din", int'(bus.tx_din), int'(m_din));
        checkOutput("grant_id", int'(grant_id), m_last);
        checkOutput("active", int'(active), int'(m_pending || m_inflight));
        if (bus.tx_wr_en) begin
          checkOutput("lit_in_range", int'(lit_rd < lit_cnt), 1);
          if (lit_rd < lit_cnt) begin
            checkOutput("lit_din", int'(bus.tx_din), int'(lit_din[lit_rd]));
            checkOutput("lit_gid", int'(grant_id), lit_gid[lit_rd]);
            lit_rd++;
          end
        end
        if (m_inflight) begin
          if (bus.tx_busy) begin
            m_seen = 1'b1;
          end else if (m_seen) begin
            m_inflight = 1'b0;
`ifdef UART_ARB_LOCK_EN
            m_lock = bus.req_lock[m_last[GW-1:0]];
`endif
          end
        end
        if (m_pending) begin
          m_pending  = 1'b0;
          m_inflight = 1'b1;
          m_seen     = 1'b0;
        end
        if (exp_ready != '0) begin
          m_pending = 1'b1;
          m_last    = win;
          m_din     = 8'(bus.req_data >> (8 * win));
          m_lock    = 1'b0;
        end
      end
      if (final_req && !final_done) begin
        checkOutput("lit_all_consumed", lit_rd, lit_cnt);
        final_done = 1'b1;
      end
    end
  end

  task automatic driveRequests();
    logic [N-1:0]   v;
    logic [8*N-1:0] d;
    v = '0;
    d = '0;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() != 0) begin
        v[i]         = 1'b1;
        d[8*i +: 8]  = src_q[i][0];
      end
    end
    bus.req_valid = v;
    bus.req_data  = d;
  endtask

  task automatic applyStimulus(input int ncycles);
    logic [N-1:0] acc;
    for (int c = 0; c < ncycles; c++) begin
      @(negedge clk_50m);
      acc = bus.req_ready & bus.req_valid;
      @(posedge clk_50m);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
      end
      driveRequests();
    end
  endtask

  task automatic pushLit(input logic [7:0] d, input int g);
    lit_din[lit_cnt] = d;
    lit_gid[lit_cnt] = g;
    lit_cnt++;
  endtask

  task automatic resetPulse(input int n);
    rst = 1'b1;
    applyStimulus(n);
    rst = 1'b0;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
`ifdef UART_ARB_LOCK_EN
    bus.req_lock  = '0;
`endif
    rst = 1'b1;
    applyStimulus(3);
    rst = 1'b0;

    $display("[TB] single requester 2");
    src_q[2].push_back(8'hA5);
    pushLit(8'hA5, 2);
    driveRequests();
    applyStimulus(40);

    $display("[TB] all four requesting from reset");
    resetPulse(2);
    src_q[0].push_back(8'h10);
    src_q[0].push_back(8'h10);
    src_q[1].push_back(8'h11);
    src_q[2].push_back(8'h12);
    src_q[3].push_back(8'h13);
    pushLit(8'h10, 0);
    pushLit(8'h11, 1);
    pushLit(8'h12, 2);
    pushLit(8'h13, 3);
    pushLit(8'h10, 0);
    driveRequests();
    applyStimulus(130);

    $display("[TB] requesters 1 and 3 alternating");
    src_q[1].push_back(8'h31);
    src_q[1].push_back(8'h32);
    src_q[3].push_back(8'h33);
    src_q[3].push_back(8'h34);
    pushLit(8'h31, 1);
    pushLit(8'h33, 3);
    pushLit(8'h32, 1);
    pushLit(8'h34, 3);
    driveRequests();
    applyStimulus(110);

    $display("[TB] transmitter busy across reset release");
    ext_busy = 1'b1;
    resetPulse(2);
    src_q[0].push_back(8'h40);
    pushLit(8'h40, 0);
    driveRequests();
    applyStimulus(10);
    ext_busy = 1'b0;
    applyStimulus(35);

    $display("[TB] reset during frame");
    src_q[1].push_back(8'h50);
    src_q[1].push_back(8'h52);
    pushLit(8'h50, 1);
    pushLit(8'h52, 1);
    driveRequests();
    applyStimulus(12);
    resetPulse(1);
    applyStimulus(60);

`ifdef UART_ARB_LOCK_EN
    $display("[TB] locked multi-byte message");
    resetPulse(2);
    src_q[0].push_back(8'h60);
    src_q[0].push_back(8'h61);
    src_q[0].push_back(8'h62);
    src_q[1].push_back(8'h70);
    pushLit(8'h60, 0);
    pushLit(8'h61, 0);
    pushLit(8'h62, 0);
    pushLit(8'h70, 1);
    bus.req_lock = 4'b0001;
    driveRequests();
    applyStimulus(4 * 23 + 15);
    bus.req_lock = '0;
    applyStimulus(5);
`endif

    final_req = 1'b1;
    repeat (3) @(posedge clk_50m);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
